// File: rtl/ahb_key_switch_in.sv
// AHB-Lite slave exposing the DE1-SoC slide switches and push-buttons as debounced
// state, sticky press events and a maskable level interrupt.
module ahb_key_switch_in #(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  input  logic [NUM_SW-1:0]  SW,
  input  logic [NUM_KEY-1:0] KEY_N,
  output logic               irq
);

  localparam int NUM_IN = NUM_SW + NUM_KEY;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_SW_STATE  = 2'd0,
    REG_KEY_STATE = 2'd1,
    REG_KEY_EVENT = 2'd2,
    REG_IRQ_EN    = 2'd3
  } reg_sel_e;

  logic [NUM_SW-1:0]             sw_meta_q, sw_meta_d;
  logic [NUM_SW-1:0]             sw_sync_q, sw_sync_d;
  logic [NUM_KEY-1:0]            key_meta_q, key_meta_d;
  logic [NUM_KEY-1:0]            key_sync_q, key_sync_d;
  logic [NUM_IN-1:0]             deb_q, deb_d;
  logic [NUM_IN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_KEY-1:0]            key_event_q, key_event_d;
  logic [NUM_KEY-1:0]            irq_en_q, irq_en_d;
  logic                          dp_write_q, dp_write_d;
  reg_sel_e                      dp_addr_q, dp_addr_d;
  logic [31:0]                   hrdata_q, hrdata_d;

  logic [NUM_IN-1:0]             level;
  logic [NUM_KEY-1:0]            key_press;
  logic [NUM_KEY-1:0]            wdata_key;
  logic [NUM_KEY-1:0]            event_view;
  logic                          w1c_event;
  logic                          wr_irq_en;
  logic                          addr_phase;
  logic                          unused_bits;

  // Two-flop synchronisers; keys are inverted afterwards so 1 means pressed.
  always_comb begin
    sw_meta_d  = SW;
    sw_sync_d  = sw_meta_q;
    key_meta_d = KEY_N;
    key_sync_d = key_meta_q;
    level      = {~key_sync_q, sw_sync_q};
  end

  // A new level is accepted only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (level[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = level[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    key_press = deb_d[NUM_IN-1:NUM_SW] & ~deb_q[NUM_IN-1:NUM_SW];
  end

  // Data-phase writes; a press accepted on the same edge as a W1C keeps its flag set.
  always_comb begin
    wdata_key   = HWDATA[NUM_KEY-1:0];
    w1c_event   = dp_write_q && (dp_addr_q == REG_KEY_EVENT);
    wr_irq_en   = dp_write_q && (dp_addr_q == REG_IRQ_EN);
    event_view  = w1c_event ? (key_event_q & ~wdata_key) : key_event_q;
    irq_en_d    = wr_irq_en ? wdata_key : irq_en_q;
    key_event_d = event_view | key_press;
  end

  // Address phase capture and read data, forwarding a write completing on the same edge.
  always_comb begin
    addr_phase = HSEL & HREADY & HTRANS[1];
    dp_write_d = addr_phase & HWRITE;
    dp_addr_d  = addr_phase ? reg_sel_e'(HADDR[3:2]) : dp_addr_q;
    hrdata_d   = '0;
    if (addr_phase && !HWRITE) begin
      case (reg_sel_e'(HADDR[3:2]))
        REG_SW_STATE: begin
          for (int b = 0; b < NUM_SW; b++) hrdata_d[b] = deb_q[b];
        end
        REG_KEY_STATE: begin
          for (int b = 0; b < NUM_KEY; b++) hrdata_d[b] = deb_q[NUM_SW+b];
        end
        REG_KEY_EVENT: begin
          for (int b = 0; b < NUM_KEY; b++) hrdata_d[b] = event_view[b];
        end
        REG_IRQ_EN: begin
          for (int b = 0; b < NUM_KEY; b++) hrdata_d[b] = irq_en_d[b];
        end
        default: hrdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      key_meta_q  <= '1;
      key_sync_q  <= '1;
      deb_q       <= '0;
      cnt_q       <= '0;
      key_event_q <= '0;
      irq_en_q    <= '0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= REG_SW_STATE;
      hrdata_q    <= '0;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      key_event_q <= key_event_d;
      irq_en_q    <= irq_en_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign HRDATA      = hrdata_q;
  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign irq         = |(key_event_q & irq_en_q);
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahb_key_switch_in.sv
// Self-checking bench for ahb_key_switch_in: table-driven bus vectors with a read
// scoreboard, plus hand-timed debounce, latency and W1C collision sequences.
module tb_ahb_key_switch_in;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [9:0]  SW;
  logic [1:0]  KEY_N;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } bus_vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [9:0]  sw;
    logic [31:0] expState;
  } sw_vec_t;

  bus_vec_t vecs[$];
  sb_t      sbQueue[$];
  sw_vec_t  swTable[11];

  ahb_key_switch_in #(.NUM_SW(10), .NUM_KEY(2), .DEBOUNCE_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .SW(SW), .KEY_N(KEY_N), .irq(irq)
  );

  always #10 HCLK = ~HCLK;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic busIdle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 32'h0;
  endtask

  task automatic addXfer(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [3:0] addr, input logic [31:0] data, input string name);
    bus_vec_t v;
    v.sel   = sel;
    v.trans = trans;
    v.wr    = wr;
    v.addr  = addr;
    v.wdata = wr ? data : 32'h0;
    v.exp   = wr ? 32'h0 : data;
    v.name  = name;
    vecs.push_back(v);
  endtask

  task automatic addWr(input logic [3:0] addr, input logic [31:0] data);
    addXfer(1'b1, 2'b10, 1'b1, addr, data, "write");
  endtask

  task automatic addRd(input logic [3:0] addr, input logic [31:0] expected, input string name);
    addXfer(1'b1, 2'b10, 1'b0, addr, expected, name);
  endtask

  // Pipelined driver: each cycle carries one address phase and the previous write's data.
  task automatic applyStimulus();
    logic [31:0] pendingData;
    logic        isRead;
    sb_t         e;
    pendingData = 32'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      HSEL   = vecs[i].sel;
      HTRANS = vecs[i].trans;
      HWRITE = vecs[i].wr;
      HADDR  = {28'h0, vecs[i].addr};
      HWDATA = pendingData;
      isRead = vecs[i].sel && vecs[i].trans[1] && !vecs[i].wr;
      if (isRead) sbQueue.push_back('{name: vecs[i].name, exp: vecs[i].exp});
      tick(1);
      pendingData = vecs[i].wdata;
      checkOutput("hreadyout", {31'b0, HREADYOUT}, 32'h1);
      checkOutput("hresp", {31'b0, HRESP}, 32'h0);
      if (isRead) begin
        if (sbQueue.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL scoreboard_underflow: got empty queue required entry");
        end else begin
          e = sbQueue.pop_front();
          checkOutput(e.name, HRDATA, e.exp);
        end
      end
    end
    busIdle();
    HWDATA = pendingData;
    tick(1);
    vecs.delete();
  endtask

  initial begin
    int swVals[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15, 12};
    int firstEdge;

    for (int i = 0; i < 11; i++) begin
      swTable[i].sw       = swVals[i][9:0];
      swTable[i].expState = swVals[i];
    end

    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HSIZE   = 3'b010;
    HWDATA  = 32'h0;
    SW      = 10'h3FF;
    KEY_N   = 2'b00;
    HSEL    = 1'b1;
    HTRANS  = 2'b10;
    HWRITE  = 1'b0;
    HADDR   = 32'h4;

    // Reads held active during reset must see zero and no interrupt.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      HADDR = {28'h0, 2'(i), 2'b00};
      checkOutput("reset_hrdata", HRDATA, 32'h0);
      checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    end
    busIdle();
    HRESETn = 1'b1;
    tick(12);

    addRd(4'h0, 32'h3FF, "post_reset_sw_state");
    addRd(4'h4, 32'h3, "post_reset_key_state");
    addRd(4'h8, 32'h3, "post_reset_key_event");
    applyStimulus();
    checkOutput("post_reset_irq_masked", {31'b0, irq}, 32'h0);

    addWr(4'h8, 32'h3);
    applyStimulus();
    KEY_N = 2'b11;
    tick(15);
    addRd(4'h4, 32'h0, "release_key_state");
    addRd(4'h8, 32'h0, "release_sets_no_event");
    applyStimulus();

    // A seven-cycle glitch must be rejected.
    KEY_N[0] = 1'b0;
    tick(7);
    KEY_N[0] = 1'b1;
    tick(15);
    addRd(4'h4, 32'h0, "glitch7_key_state");
    addRd(4'h8, 32'h0, "glitch7_key_event");
    applyStimulus();

    // An eight-cycle press is accepted on edge 10 after the first sampling edge.
    addWr(4'hC, 32'h1);
    applyStimulus();
    firstEdge = -1;
    KEY_N[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 8) KEY_N[0] = 1'b1;
      if (irq && firstEdge < 0) firstEdge = k;
    end
    checkOutput("press8_latency_edge", 32'(firstEdge), 32'd10);
    addRd(4'h8, 32'h1, "press8_key_event");
    addRd(4'h4, 32'h0, "press8_released_state");
    addWr(4'h8, 32'h1);
    addWr(4'hC, 32'h0);
    addRd(4'h8, 32'h0, "press8_cleared");
    applyStimulus();

    for (int i = 0; i < 11; i++) begin
      SW = swTable[i].sw;
      tick(50);
      addRd(4'h0, swTable[i].expState, $sformatf("sw_state_%0d", i));
      applyStimulus();
    end
    addRd(4'h8, 32'h0, "sw_no_key_event");
    applyStimulus();

    addWr(4'hC, 32'h2);
    applyStimulus();
    KEY_N[1] = 1'b0;
    tick(50);
    KEY_N[1] = 1'b1;
    tick(20);
    checkOutput("key1_irq_set", {31'b0, irq}, 32'h1);
    addRd(4'h8, 32'h2, "key1_event");
    addWr(4'h8, 32'h1);
    addRd(4'h8, 32'h2, "w1c_other_bit");
    applyStimulus();
    checkOutput("w1c_other_irq", {31'b0, irq}, 32'h1);
    addWr(4'h8, 32'h2);
    addRd(4'h8, 32'h0, "w1c_clear");
    applyStimulus();
    checkOutput("w1c_irq_clear", {31'b0, irq}, 32'h0);

    // W1C data-phase edge coincides with acceptance of a new key 0 press.
    KEY_N[0] = 1'b0;
    tick(8);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = 32'h8;
    tick(1);
    busIdle();
    HWDATA = 32'h1;
    tick(1);
    KEY_N[0] = 1'b1;
    addRd(4'h8, 32'h1, "collision_set_wins");
    applyStimulus();
    checkOutput("collision_irq_masked", {31'b0, irq}, 32'h0);
    tick(15);
    addWr(4'h8, 32'h3);
    addRd(4'h8, 32'h0, "collision_cleanup");
    applyStimulus();

    addWr(4'hC, 32'h3);
    addRd(4'hC, 32'h3, "b2b_irq_en");
    addXfer(1'b1, 2'b00, 1'b1, 4'hC, 32'h0, "idle_write");
    addRd(4'hC, 32'h3, "idle_no_change");
    addXfer(1'b0, 2'b10, 1'b1, 4'hC, 32'h0, "unselected_write");
    addRd(4'hC, 32'h3, "unselected_no_change");
    addXfer(1'b1, 2'b01, 1'b1, 4'hC, 32'h0, "busy_write");
    addRd(4'hC, 32'h3, "busy_no_change");
    addWr(4'h0, 32'h5);
    addRd(4'h0, 32'hC, "ro_sw_state");
    addWr(4'h4, 32'h3);
    addRd(4'h4, 32'h0, "ro_key_state");
    addRd(4'h0, 32'hC, "b2b_read_sw");
    addRd(4'h8, 32'h0, "b2b_read_event");
    addWr(4'hC, 32'hFFFF_FFFD);
    addRd(4'hC, 32'h1, "irq_en_unused_bits");
    applyStimulus();
    checkOutput("final_irq", {31'b0, irq}, 32'h0);
    checkOutput("scoreboard_empty", 32'(sbQueue.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_key_switch_in.md
# ahb_key_switch_in

AHB-Lite slave peripheral that receives the DE1-SoC push-buttons and slide switches, synchronises and debounces them, and latches button presses as sticky events for the Cortex-M0 software. It sits on the AHB bus beside the LED/HEX/VGA output peripherals inside `de1_soc_wrapper`, on the input side of the board interface. It raises an interrupt on any enabled press event.

## Interface
- `NUM_SW`, 10, number of slide switches (1..32)
- `NUM_KEY`, 2, number of user push-buttons (1..32; the reset key is excluded)
- `DEBOUNCE_CYCLES`, 8, cycles a synchronised input must hold a new level before it is accepted (>=1)
- `HCLK  input  1  system clock, all logic on rising edge`
- `HRESETn  input  1  reset, asynchronous, active-low`
- `HSEL  input  1  slave select`
- `HADDR  input  32  address; only [3:2] decoded`
- `HTRANS  input  2  transfer type; [1]=1 means NONSEQ/SEQ`
- `HWRITE  input  1  1=write`
- `HSIZE  input  3  ignored; all accesses treated as 32-bit`
- `HWDATA  input  32  write data (data phase)`
- `HREADY  input  1  bus ready`
- `HRDATA  output  32  read data (data phase)`
- `HREADYOUT  output  1  constant 1, no wait states`
- `HRESP  output  1  constant 0, OKAY`
- `SW  input  NUM_SW  raw switches, asynchronous, 1=up`
- `KEY_N  input  NUM_KEY  raw buttons, asynchronous, active-low`
- `irq  output  1  interrupt, active-high level`

## Operation
- Per input: 2-flop synchroniser; KEY_N inverted after sync, so internal level 1=pressed.
- Per input debouncer: counter clears while synced==debounced; while they differ it increments; on a mismatch cycle with counter==DEBOUNCE_CYCLES-1, debounced<=synced and counter<=0. A mismatch that ends before acceptance clears the counter, so pulses shorter than DEBOUNCE_CYCLES cycles never appear.
- Press event: debounced key 0->1 sets KEY_EVENT[i]. Releases set nothing.
- Registers, HADDR[3:2]:
  - 0x0 SW_STATE (RO): debounced switches in [NUM_SW-1:0].
  - 0x4 KEY_STATE (RO): debounced keys, 1=pressed.
  - 0x8 KEY_EVENT (W1C): sticky press flags; writing 1 clears the bit, writing 0 has no effect.
  - 0xC IRQ_EN (RW): per-key interrupt mask.
- Unused bits read 0. Writes to RO registers are ignored.
- irq = |(KEY_EVENT & IRQ_EN), derived from registers with no extra delay.
- Simultaneous new press and W1C on the same bit: the set wins and the bit stays 1.
- Reset values: sync flops SW=0, KEY=not pressed; debounced state 0; counters 0; KEY_EVENT=0; IRQ_EN=0; HRDATA=0; irq=0. Asserting HRESETn mid-debounce discards the partial count.

## Timing
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. Register HWRITE and HADDR[3:2].
- Read: HRDATA is registered at the address-phase edge and valid throughout the next (data) cycle. It reflects register contents before that edge.
- Write: HWDATA is sampled at the end of the data phase. The target register updates on that edge, and the new value is visible to a read whose address phase follows.
- Back-to-back transfers are supported with zero wait states. A read immediately after a write to the same register returns the written value.
- Input latency: counting the first edge that samples a new stable raw level as edge 1, SW_STATE/KEY_STATE update on edge DEBOUNCE_CYCLES+2. For a press, KEY_EVENT and irq rise on that same edge.

## Test plan
- Reset: HRESETn low with SW=0x3FF and KEY_N=2'b00 -> all reads 0 and irq=0 during reset. After release, SW_STATE=0x3FF and KEY_STATE=0x3 within 10 cycles, KEY_EVENT=0x3.
- Debounce: KEY_N[0] low for 7 cycles then high -> KEY_STATE and KEY_EVENT stay 0. Low for 8 cycles -> KEY_STATE[0]=1 exactly on edge 10 after the first sampling edge, and KEY_EVENT=0x1.
- Switches: SW stepped 0,1,2,3,4,5,6,7,8,15,12, each held >=1 us at 50 MHz -> SW_STATE read back equals each value. KEY_EVENT is unchanged.
- W1C and interrupt: IRQ_EN=0x2, press key 1 (1 us) -> irq=1 and KEY_EVENT=0x2. Write 0x1 -> still 0x2. Write 0x2 -> 0 and irq=0.
- Collision: time the W1C 0x1 data-phase edge to coincide with a new key 0 press acceptance -> KEY_EVENT[0]=1 afterwards.
- Bus: back-to-back write IRQ_EN=0x3 then read 0xC -> 0x3. HREADYOUT=1 and HRESP=0 throughout. Transfer with HTRANS=IDLE or HSEL=0 -> no register change.
